// File: rtl/spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave
// Purpose  : Byte-oriented SPI slave (mode 0, MSB first) clocked by the system
//            clock. SCK/SSEL/MOSI are synchronized and edge-detected in the clk
//            domain. Each received byte is presented with a one-cycle strobe;
//            a caller-supplied byte is shifted out on MISO.
// Ports    : clk           - system clock (>= 4x SCK)
//            rst_n         - asynchronous active-low reset
//            SCK/MOSI/SSEL - SPI pins from the master (asynchronous)
//            MISO          - slave serial output, tx_shift[7]
//            data_ready    - one-clk pulse when data_recv holds a new byte
//            data_recv     - last complete received byte
//            data_send     - byte to transmit, captured at byte boundaries
//            bit_count_out - bits received so far in the current byte
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       SCK,
  input  logic       MOSI,
  output logic       MISO,
  input  logic       SSEL,
  output logic       data_ready,
  output logic [7:0] data_recv,
  input  logic [7:0] data_send,
  output logic [2:0] bit_count_out
);

  // Synchronizer chains; the newest sample enters at bit 0.
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] ssel_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sck_hist;
  logic                   ssel_hist;

  logic sck_s;
  logic ssel_s;
  logic mosi_s;
  logic sck_rise;
  logic sck_fall;
  logic ssel_act;
  logic ssel_start;

  logic [6:0] rx_shift;
  logic [2:0] bit_count;
  logic [7:0] tx_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync  <= '0;
      ssel_sync <= {SYNC_STAGES{1'b1}};
      mosi_sync <= '0;
      sck_hist  <= 1'b0;
      ssel_hist <= 1'b1;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
      ssel_sync <= {ssel_sync[SYNC_STAGES-2:0], SSEL};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
      sck_hist  <= sck_sync[SYNC_STAGES-1];
      ssel_hist <= ssel_sync[SYNC_STAGES-1];
    end
  end

  assign sck_s      = sck_sync[SYNC_STAGES-1];
  assign ssel_s     = ssel_sync[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync[SYNC_STAGES-1];
  assign sck_rise   = sck_s & ~sck_hist;
  assign sck_fall   = ~sck_s & sck_hist;
  assign ssel_act   = ~ssel_s;
  assign ssel_start = ~ssel_s & ssel_hist;

  // Receive path. Deselect discards any partial byte and resets bit position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift   <= '0;
      bit_count  <= '0;
      data_recv  <= '0;
      data_ready <= 1'b0;
    end else begin
      data_ready <= 1'b0;
      if (!ssel_act) begin
        rx_shift  <= '0;
        bit_count <= '0;
      end else if (sck_rise) begin
        rx_shift  <= {rx_shift[5:0], mosi_s};
        bit_count <= bit_count + 3'd1;
        if (bit_count == 3'd7) begin
          data_recv  <= {rx_shift, mosi_s};
          data_ready <= 1'b1;
        end
      end
    end
  end

  // Transmit path. A falling edge with bit_count==0 follows the eighth rise,
  // so that is where the next byte is fetched; frame start takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift <= '0;
    end else if (ssel_start) begin
      tx_shift <= data_send;
    end else if (sck_fall && ssel_act) begin
      if (bit_count == 3'd0) begin
        tx_shift <= data_send;
      end else begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end
    end
  end

  assign MISO          = tx_shift[7];
  assign bit_count_out = bit_count;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave
// Purpose  : Self-checking bench for spi_slave. Acts as an SPI master with
//            SCK = clk/8; the reference model is simply the byte queues sent
//            by the master (MOSI) and offered to the slave (data_send).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       SCK = 1'b0;
  logic       MOSI = 1'b0;
  logic       MISO;
  logic       SSEL = 1'b1;
  logic       data_ready;
  logic [7:0] data_recv;
  logic [7:0] data_send = 8'h00;
  logic [2:0] bit_count_out;

  int compared = 0;
  int mismatched = 0;
  int pulse_count = 0;
  logic prev_ready = 1'b0;

  logic [7:0] mbytes[16];
  logic [7:0] sbytes[16];
  logic [7:0] tail_send;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  spi_slave #(.SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .SCK          (SCK),
    .MOSI         (MOSI),
    .MISO         (MISO),
    .SSEL         (SSEL),
    .data_ready   (data_ready),
    .data_recv    (data_recv),
    .data_send    (data_send),
    .bit_count_out(bit_count_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Byte-level monitor: every strobe must be a single clock wide.
  always @(negedge clk) begin
    if (rst_n && data_ready) begin
      pulse_count++;
      got_q.push_back(data_recv);
      check("ready_width", {31'd0, prev_ready}, 32'd0);
    end
    prev_ready <= rst_n & data_ready;
  end

  // Runs one SSEL frame of nbytes. If abort_bits > 0 the last byte is cut
  // short after that many bits and never counts as received.
  task automatic run_frame(input int nbytes, input int abort_bits);
    int nbits;
    data_send = sbytes[0];
    wait_clk(1);
    SSEL = 1'b0;
    wait_clk(8);
    for (int b = 0; b < nbytes; b++) begin
      nbits = (abort_bits > 0 && b == nbytes - 1) ? abort_bits : 8;
      for (int i = 0; i < nbits; i++) begin
        MOSI = mbytes[b][7-i];
        wait_clk(4);
        check("bit_count", {29'd0, bit_count_out}, i);
        check("miso_bit", {31'd0, MISO}, {31'd0, sbytes[b][7-i]});
        SCK = 1'b1;
        if (i == 7) begin
          tail_send = (b + 1 < nbytes) ? sbytes[b+1] : 8'($urandom);
          data_send = tail_send;
        end
        wait_clk(4);
        SCK = 1'b0;
      end
      if (nbits == 8) exp_q.push_back(mbytes[b]);
    end
    wait_clk(6);
    if (abort_bits == 0) check("miso_tail", {31'd0, MISO}, {31'd0, tail_send[7]});
    SSEL = 1'b1;
    wait_clk(8);
    check("idle_count", {29'd0, bit_count_out}, 32'd0);
    check("byte_total", got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check("rx_byte", {24'd0, got_q[k]}, {24'd0, exp_q[k]});
    if (exp_q.size() > 0) check("recv_hold", {24'd0, data_recv}, {24'd0, exp_q[exp_q.size()-1]});
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    int pc;
    int n;
    logic [7:0] last_full;

    // Reset state.
    wait_clk(3);
    check("rst_ready", {31'd0, data_ready}, 32'd0);
    check("rst_recv", {24'd0, data_recv}, 32'd0);
    check("rst_count", {29'd0, bit_count_out}, 32'd0);
    check("rst_miso", {31'd0, MISO}, 32'd0);
    rst_n = 1'b1;
    wait_clk(4);

    // Single byte 0xA5.
    mbytes[0] = 8'hA5; sbytes[0] = 8'h5A;
    run_frame(1, 0);

    // Back-to-back bytes in one frame.
    mbytes[0] = 8'h01; mbytes[1] = 8'h12; mbytes[2] = 8'h34; mbytes[3] = 8'h56;
    for (int k = 0; k < 4; k++) sbytes[k] = 8'($urandom);
    run_frame(4, 0);

    // Transmit 0x3C then 0xC3.
    mbytes[0] = 8'h00; mbytes[1] = 8'hFF;
    sbytes[0] = 8'h3C; sbytes[1] = 8'hC3;
    run_frame(2, 0);

    // SCK toggling while deselected: nothing moves.
    pc = pulse_count;
    for (int k = 0; k < 12; k++) begin
      MOSI = 1'($urandom);
      SCK = ~SCK;
      wait_clk(4);
      check("desel_count", {29'd0, bit_count_out}, 32'd0);
    end
    SCK = 1'b0;
    wait_clk(6);
    check("desel_pulses", pulse_count, pc);
    check("desel_miso", {31'd0, MISO}, {31'd0, tail_send[7]});

    // Abort after 5 bits, then a full 0xFF frame.
    mbytes[0] = 8'h9B; sbytes[0] = 8'hE1;
    run_frame(1, 5);
    mbytes[0] = 8'hFF; sbytes[0] = 8'h81;
    run_frame(1, 0);

    // Randomized frames, some aborted.
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) begin
        mbytes[k] = 8'($urandom);
        sbytes[k] = 8'($urandom);
      end
      run_frame(n, (f % 3 == 2) ? $urandom_range(1, 7) : 0);
    end

    // Reset in the middle of a frame.
    mbytes[0] = 8'h7E; sbytes[0] = 8'hB6;
    run_frame(1, 0);
    last_full = 8'h7E;
    check("pre_rst_recv", {24'd0, data_recv}, {24'd0, last_full});
    data_send = 8'hFF;
    wait_clk(1);
    SSEL = 1'b0;
    wait_clk(8);
    for (int i = 0; i < 3; i++) begin
      MOSI = 1'b1;
      wait_clk(4); SCK = 1'b1;
      wait_clk(4); SCK = 1'b0;
    end
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, data_ready}, 32'd0);
    check("mid_rst_recv", {24'd0, data_recv}, 32'd0);
    check("mid_rst_count", {29'd0, bit_count_out}, 32'd0);
    check("mid_rst_miso", {31'd0, MISO}, 32'd0);
    SSEL = 1'b1;
    wait_clk(3);
    pc = pulse_count;
    rst_n = 1'b1;
    wait_clk(20);
    check("post_rst_pulses", pulse_count, pc);
    check("post_rst_recv", {24'd0, data_recv}, 32'd0);

    mbytes[0] = 8'h42; sbytes[0] = 8'h99;
    run_frame(1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
